comm_ctrl: RTL and testbench
============================

COMM_CTRL -- requirements
Module: comm_ctrl

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per UART bit time (legal range 8 to 65535).
REQ-002 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port RX, input, 1, serial line from the host; asynchronous; idle high.
REQ-005 SHALL have port TX, output, 1, serial line to the host; idle high.
REQ-006 SHALL have port cmd, output, 24, assembled host command.
REQ-007 SHALL have port cmd_rdy, output, 1, cmd is valid.
REQ-008 SHALL have port clr_cmd_rdy, input, 1, core acknowledges cmd.
REQ-009 SHALL have port resp_data, input, 8, response byte from the core.
REQ-010 SHALL have port send_resp, input, 1, single-cycle request to transmit resp_data.
REQ-011 SHALL have port resp_sent, output, 1, single-cycle pulse when the response has been fully sent.
REQ-012 SHALL have port tx_busy, output, 1, transmitter is active.
REQ-013 SHALL have port overrun, output, 1, single-cycle pulse when a command is dropped.
REQ-014 SHALL have port frm_err, output, 1, single-cycle pulse on an RX stop-bit error.

Function
REQ-015 UART format SHALL be 8N1, LSB first, one bit time = BAUD_DIV clocks.
REQ-016 RX SHALL pass through a 2-flop synchronizer before any use.
REQ-017 Receiver FSM SHALL use states IDLE, START, DATA and STOP.
- IDLE -> START on a synchronized falling edge.
- START: sample at BAUD_DIV/2; if the sample is high (false start), return to IDLE.
- DATA: 8 samples, one every BAUD_DIV clocks from the mid-start point.
- STOP: one sample, then return to IDLE.
REQ-018 A stop sample of 0 SHALL discard the byte, reset the byte counter to 0 and pulse frm_err.
REQ-019 Received bytes SHALL be assembled MSB-first: byte0 -> cmd[23:16], byte1 -> cmd[15:8], byte2 -> cmd[7:0].
- A 2-bit byte counter wraps to 0 after byte2.
REQ-020 On byte2 completion, cmd SHALL load all 24 bits and cmd_rdy SHALL rise on the next clock.
- cmd is unchanged while cmd_rdy is 1.
REQ-021 cmd_rdy SHALL stay 1 until clr_cmd_rdy is sampled high, and be 0 on the following clock.
REQ-022 Byte reception SHALL continue while cmd_rdy is 1.
- If byte2 completes while cmd_rdy is 1 and clr_cmd_rdy is 0: drop the new command, keep cmd, pulse overrun.
REQ-023 If clr_cmd_rdy and byte2 completion occur in the same cycle, SHALL load the new cmd, keep cmd_rdy at 1, and not pulse overrun.
REQ-024 Transmitter FSM SHALL use states IDLE, START, DATA and STOP.
- send_resp in IDLE captures resp_data into a shift register and sets tx_busy on the next clock.
- TX drives the start bit, then 8 data bits, then the stop bit, each for BAUD_DIV clocks.
REQ-025 resp_sent SHALL pulse for exactly one cycle at the end of the stop bit; tx_busy SHALL fall in the same cycle.
REQ-026 send_resp while tx_busy is 1 SHALL be ignored; resp_data changes after capture SHALL not affect the byte in flight.
REQ-027 send_resp in the same cycle as resp_sent SHALL be ignored; the core waits for tx_busy to be 0.
REQ-028 RX and TX paths SHALL be fully independent and run concurrently.
REQ-029 Baud counters SHALL be 16 bits and SHALL reload on every state entry.

Reset
REQ-030 While rst is 1, on the clock edge:
- TX = 1; cmd = 0; cmd_rdy, resp_sent, tx_busy, overrun, frm_err = 0.
- Both FSMs go to IDLE; byte counter = 0; synchronizer flops = 1.
REQ-031 Reset mid-frame SHALL abort the frame.
- A partial command is discarded.
- TX returns high on the same edge; no resp_sent is issued for the aborted byte.

Structure
REQ-032 The shared package SHALL hold the uart_state_t enum (IDLE/START/DATA/STOP), CMD_W = 24 and BYTE_W = 8.
REQ-033 Transmitter SHALL be sub-module uart_tx (clk, rst, tx_start, tx_data, TX, tx_busy, tx_done); receive and assembly logic SHALL be inline.

Verification
REQ-034 Benches SHALL use BAUD_DIV = 8, with TX looped to RX through a host model. Required scenarios:
- Send bytes 0x12, 0x34, 0x56 -> cmd = 0x123456; cmd_rdy rises 1 clock after byte2's stop sample and holds until clr_cmd_rdy; then 0 next clock.
- send_resp with resp_data = 0xA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks; resp_sent pulses once at 80 clocks after start; second send_resp at clock 20 is ignored.
- Second command 0xABCDEF completes with cmd_rdy still 1 and no clr_cmd_rdy -> cmd stays 0x123456; overrun pulses once.
- Byte with stop bit = 0 after byte0 -> frm_err pulses; the next three good bytes 0x01, 0x02, 0x03 yield cmd = 0x010203.
- 3-clock low glitch on RX -> no byte received and no state change.
- rst asserted mid-byte1 of RX and mid-bit4 of TX -> all outputs at reset values next clock; a fresh 3-byte command then decodes correctly.

Source files
------------

// File: rtl/comm_ctrl_pkg.sv
// Shared types and widths for the host command link (UART receiver, command
// assembler and response transmitter).
package comm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int CMD_W      = 24;
  localparam int BYTE_W     = 8;
  localparam int BAUD_CNT_W = 16;

endpackage

// File: rtl/comm_ctrl_uart_tx.sv
// 8N1 UART transmitter: captures one byte on tx_start and shifts it out LSB
// first, pulsing tx_done as the stop bit ends.
module uart_tx
  import comm_ctrl_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [BAUD_CNT_W-1:0] BIT_LAST = BAUD_CNT_W'(BAUD_DIV - 1);

  uart_state_t           state_q, state_d;
  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [BYTE_W-1:0]     shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != IDLE) cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        // A request coinciding with the done pulse is dropped on purpose.
        if (tx_start && !done_q) begin
          state_d = START;
          cnt_d   = BIT_LAST;
          shift_d = tx_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = BIT_LAST;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = BIT_LAST;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign TX      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: rtl/comm_ctrl.sv
// Host command link: receives 3-byte commands over UART into cmd/cmd_rdy and
// transmits single response bytes back on TX.
module comm_ctrl
  import comm_ctrl_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  output logic              TX,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp_data,
  input  logic              send_resp,
  output logic              resp_sent,
  output logic              tx_busy,
  output logic              overrun,
  output logic              frm_err
);

  localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(BAUD_DIV / 2 - 1);

  logic                  rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t           rx_state_q, rx_state_d;
  logic [BAUD_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [BYTE_W-1:0]     rx_shift_q, rx_shift_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           asm_q, asm_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;
  logic                  rx_fall, rx_bit_end, byte_done;

  assign rx_fall    = rx_prev_q & ~rx_s2_q;
  assign rx_bit_end = (rx_cnt_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    byte_done  = 1'b0;
    if (rx_state_q != IDLE) rx_cnt_d = rx_cnt_q - 1'b1;
    case (rx_state_q)
      IDLE: begin
        if (rx_fall) begin
          rx_state_d = START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      START: begin
        if (rx_bit_end) begin
          if (rx_s2_q) begin
            rx_state_d = IDLE;
          end else begin
            rx_state_d = DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[BYTE_W-1:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      STOP: begin
        if (rx_bit_end) begin
          rx_state_d = IDLE;
          if (rx_s2_q) begin
            byte_done = 1'b1;
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = 2'd0;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase

    if (cmd_rdy_q && clr_cmd_rdy) cmd_rdy_d = 1'b0;

    // Bytes arrive MSB-first; the third byte either publishes or is dropped.
    if (byte_done) begin
      case (byte_cnt_q)
        2'd0: begin
          asm_d[15:8] = rx_shift_q;
          byte_cnt_d  = 2'd1;
        end
        2'd1: begin
          asm_d[7:0] = rx_shift_q;
          byte_cnt_d = 2'd2;
        end
        default: begin
          byte_cnt_d = 2'd0;
          if (!cmd_rdy_q || clr_cmd_rdy) begin
            cmd_d     = {asm_q, rx_shift_q};
            cmd_rdy_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      byte_cnt_q <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    asm_q      <= asm_d;
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign overrun = ovr_q;
  assign frm_err = ferr_q;

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(send_resp),
    .tx_data (resp_data),
    .TX      (TX),
    .tx_busy (tx_busy),
    .tx_done (resp_sent)
  );

endmodule

// File: tb/tb_comm_ctrl.sv
// Scoreboard bench for comm_ctrl at BAUD_DIV = 8: a host model drives RX frames
// and decodes TX frames while monitors compare DUT outputs to queued expectations.
module tb_comm_ctrl;

  localparam int BD = 8;
  // Stop sample = 2 sync flops + edge detect + half bit + 8 data bits + 1 bit.
  localparam int RDY_LAT = 3 + BD / 2 + 8 * BD + BD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        TX, cmd_rdy, resp_sent, tx_busy, overrun, frm_err;
  logic [23:0] cmd;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int rx_t0 = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_sent_t_q[$];

  comm_ctrl #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp_data  (resp_data),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent),
    .tx_busy    (tx_busy),
    .overrun    (overrun),
    .frm_err    (frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    @(posedge clk);
    #1;
    rx_t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) tick();
    end
    RX = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_cmd(input logic [23:0] c, input bit expect_rdy);
    if (expect_rdy) exp_cmd_q.push_back(c);
    send_byte(c[23:16], 1'b1);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
    repeat (3) tick();
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  // Output monitor: cmd_rdy rises, status pulses, resp_sent timing.
  initial begin : monitor
    logic rdy_prev, ovr_prev, ferr_prev, sent_prev;
    rdy_prev = 1'b0; ovr_prev = 1'b0; ferr_prev = 1'b0; sent_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && !rdy_prev) begin
        if (exp_cmd_q.size() == 0) begin
          check("cmd_rdy_unexpected", 1, 0);
        end else begin
          check("cmd_value", cmd, exp_cmd_q.pop_front());
          check("cmd_rdy_latency", cyc - rx_t0, RDY_LAT);
        end
      end
      if (overrun === 1'b1) begin
        ovr_cnt++;
        check("overrun_pulse_width", ovr_prev, 0);
      end
      if (frm_err === 1'b1) begin
        ferr_cnt++;
        check("frm_err_pulse_width", ferr_prev, 0);
      end
      if (resp_sent === 1'b1) begin
        check("resp_sent_pulse_width", sent_prev, 0);
        check("tx_busy_low_at_resp_sent", tx_busy, 0);
        if (exp_sent_t_q.size() == 0) check("resp_sent_unexpected", 1, 0);
        else                          check("resp_sent_time", cyc, exp_sent_t_q.pop_front());
      end
      rdy_prev  = (cmd_rdy === 1'b1);
      ovr_prev  = (overrun === 1'b1);
      ferr_prev = (frm_err === 1'b1);
      sent_prev = (resp_sent === 1'b1);
    end
  end

  // Host-side TX decoder: every bit must hold its value for all BD samples.
  initial begin : tx_monitor
    logic [9:0] bits;
    int         mism;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || TX !== 1'b0) continue;
      if (exp_tx_q.size() == 0) begin
        check("tx_frame_unexpected", 1, 0);
        for (int i = 0; i < 10 * BD; i++) begin
          @(negedge clk);
          if (rst) break;
        end
        continue;
      end
      bits    = {1'b1, exp_tx_q.pop_front(), 1'b0};
      aborted = 1'b0;
      for (int k = 0; k < 10 && !aborted; k++) begin
        mism = 0;
        for (int j = 0; j < BD; j++) begin
          if (k > 0 || j > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (TX !== bits[k]) mism++;
        end
        if (!aborted) check($sformatf("tx_bit%0d_bad_samples", k), mism, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual cycle %0d, expected under 50000", cyc);
    $fatal(1);
  end

  initial begin : main
    int ovr0, ferr0, t;
    bit seen;

    // Reset state
    repeat (3) tick();
    check("reset_ctrl_outputs", {TX, cmd_rdy, resp_sent, tx_busy, overrun, frm_err}, 6'b100000);
    check("reset_cmd", cmd, 24'h0);
    rst = 1'b0;
    repeat (5) tick();

    // First command, held until acknowledged
    send_cmd(24'h123456, 1'b1);
    repeat (20) tick();
    check("cmd_rdy_holds", cmd_rdy, 1);

    // Overrun: new command while the first is unacknowledged
    ovr0 = ovr_cnt;
    send_cmd(24'hABCDEF, 1'b0);
    repeat (3) tick();
    check("overrun_count", ovr_cnt - ovr0, 1);
    check("cmd_kept_on_overrun", cmd, 24'h123456);
    check("cmd_rdy_kept_on_overrun", cmd_rdy, 1);
    pulse_clr();
    check("cmd_rdy_cleared", cmd_rdy, 0);

    // Response 0xA5, with an ignored request mid-frame
    resp_data = 8'hA5;
    send_resp = 1'b1;
    exp_tx_q.push_back(8'hA5);
    exp_sent_t_q.push_back(cyc + 1 + 10 * BD);
    tick();
    send_resp = 1'b0;
    check("tx_busy_after_capture", tx_busy, 1);
    repeat (18) tick();
    resp_data = 8'h3C;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = (resp_sent === 1'b1);
    end
    check("resp_sent_seen", seen, 1);
    // Request in the resp_sent cycle must not start a frame
    resp_data = 8'h77;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    repeat (3) tick();
    check("tx_idle_after_late_request", {tx_busy, TX}, 2'b01);

    // Framing error after byte0, then a clean command
    ferr0 = ferr_cnt;
    send_byte(8'h77, 1'b1);
    send_byte(8'h99, 1'b0);
    repeat (4) tick();
    check("frm_err_count", ferr_cnt - ferr0, 1);
    check("cmd_rdy_after_frm_err", cmd_rdy, 0);
    send_cmd(24'h010203, 1'b1);
    pulse_clr();

    // Short low glitch between bytes of a command
    exp_cmd_q.push_back(24'hDEADBE);
    send_byte(8'hDE, 1'b1);
    RX = 1'b0;
    repeat (3) tick();
    RX = 1'b1;
    repeat (12) tick();
    check("glitch_no_frm_err", ferr_cnt - ferr0, 1);
    check("glitch_no_cmd_rdy", cmd_rdy, 0);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    repeat (3) tick();
    check("glitch_cmd_rdy", cmd_rdy, 1);

    // Acknowledge in the very cycle the next command completes
    ovr0 = ovr_cnt;
    send_byte(8'h0F, 1'b1);
    send_byte(8'h1E, 1'b1);
    fork
      send_byte(8'h2D, 1'b1);
      begin
        tick();
        repeat (RDY_LAT - 1) @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
      end
    join
    check("same_cycle_clr_cmd", cmd, 24'h0F1E2D);
    check("same_cycle_clr_rdy", cmd_rdy, 1);
    check("same_cycle_clr_no_overrun", ovr_cnt - ovr0, 0);

    // Reset mid RX byte1 and mid TX bit4
    fork
      begin
        logic [9:0] f;
        send_byte(8'h11, 1'b1);
        f = {1'b1, 8'h22, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
          RX = f[i];
          repeat (BD) tick();
        end
      end
      begin
        repeat (80) tick();
        resp_data = 8'h4B;
        send_resp = 1'b1;
        exp_tx_q.push_back(8'h4B);
        tick();
        send_resp = 1'b0;
      end
    join
    check("pre_reset_tx_bit4", {tx_busy, TX}, 2'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    RX  = 1'b1;
    tick();
    check("midframe_reset_ctrl", {TX, cmd_rdy, resp_sent, tx_busy, overrun, frm_err}, 6'b100000);
    check("midframe_reset_cmd", cmd, 24'h0);
    rst = 1'b0;
    t = ferr_cnt;
    repeat (100) tick();
    check("post_reset_quiet", {tx_busy, cmd_rdy, 8'(ferr_cnt - t)}, 10'h0);
    send_cmd(24'hC0FFEE, 1'b1);
    pulse_clr();
    check("final_cmd_rdy_cleared", cmd_rdy, 0);

    repeat (20) tick();
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("sent_queue_drained", exp_sent_t_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
